act_lut_interp: RTL
===================

Name: act_lut_interp

Overview:
- Initiator/consumer side of the activation-function LUT interface in the neural-network layers.
- Accepts a stream of signed pre-activation values and drives the LUT address.
- Takes the combinational base/next_data pair back from the LUT and linearly interpolates between them.
- Emits the activation value on a valid/ready stream with full throughput and backpressure.

Parameters:
- DATA_W, 8, width of the signed sample and of the LUT entries.
- ADDR_W, 4, LUT address width; the index is in_data[DATA_W-1 -: ADDR_W].
- FRAC_W, DATA_W-ADDR_W (4), fraction bits used for interpolation.
- CNT_W, 16, width of the delivered-sample counter.

Ports:
- clk  in  1  Single clock, rising edge.
- rst_n  in  1  Asynchronous reset, active-low.
- in_valid  in  1  Input sample valid.
- in_ready  out  1  Block can accept a sample this cycle.
- in_data  in  DATA_W  Signed pre-activation value.
- lut_address  out  ADDR_W  Address to the LUT.
- lut_base  in  DATA_W  Signed LUT value at lut_address.
- lut_next  in  DATA_W  Signed interpolation endpoint from the LUT.
- out_valid  out  1  Output valid.
- out_ready  in  1  Downstream accepts.
- out_data  out  DATA_W  Signed interpolated activation.
- out_count  out  CNT_W  Number of output handshakes completed; wraps modulo 2^CNT_W.

Behaviour:
- Reset (rst_n low, asynchronous): v1=0, x1=0, out_valid=0, out_data=0, out_count=0. in_ready reads 1 once rst_n is high. lut_address=0.
- Stage 1 register: x1/v1 capture in_data on an input handshake (in_valid && in_ready).
- lut_address = x1[DATA_W-1 -: ADDR_W], always driven from the register. It holds stable while stage 1 stalls.
- frac = x1[FRAC_W-1:0], unsigned.
- Stage 2 (combinational on the registered x1 and the LUT returns):
  - diff = lut_next - lut_base, DATA_W+1 bits signed.
  - prod = diff * frac, DATA_W+FRAC_W+1 bits signed.
  - y = lut_base + (prod >>> FRAC_W), arithmetic shift.
  - Saturate y to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- Output register: out_data/out_valid load y/v1 when adv2 = !out_valid || out_ready.
- Stage 1 advances when adv2. in_ready = !v1 || adv2, so there is no combinational path from in_valid to in_ready.
- Latency: a sample accepted at edge N shows out_valid=1 after edge N+1, i.e. two register stages. Throughput is 1 sample/cycle when out_ready=1.
- Stall: out_valid && !out_ready holds out_data, x1 and lut_address stable. in_ready drops once v1=1.
- Boundary behaviour is handled by the LUT:
  - Top positive index: lut_next==lut_base, so y=base.
  - Index 2^ADDR_W-1: lut_next is entry 0, giving wrap toward zero.
  - The block treats both as ordinary data.
- Simultaneous events: input and output handshakes in the same cycle are legal and keep the pipe full.
- out_count increments on every out_valid && out_ready.
- Reset mid-operation: in-flight samples are discarded and all state returns to reset values immediately. No output handshake completes during reset.

Optional Feature:
- ACT_INTERP_ROUND_EN defined: add 2^(FRAC_W-1) to prod before the shift, giving round-half-up.
- ACT_INTERP_ROUND_EN undefined: truncation toward -inf via the plain arithmetic shift.
- Latency and interface are identical in both builds.

Decomposition:
- Package act_lut_pkg holds:
  - DATA_W, ADDR_W, FRAC_W and CNT_W defaults.
  - typedefs sample_t (signed DATA_W), addr_t, frac_t.
  - function sat_data() for saturation.
- One natural sub-module: act_interp_core, the combinational diff/multiply/shift/round/saturate datapath. act_lut_interp keeps the handshake registers and the counter.

Test Plan:
- Identity LUT (entry i = 16*signed(i)), in_data=0x25 -> lut_address=2, out_data=37 (0x25) after 2 cycles, out_count=1.
- Same LUT, in_data=0x7F -> address 7, base=next=112, out_data=112; in_data=0xFF -> address 15, base=-16, next=0, frac=15, out_data=-1.
- in_data=0x80 -> out_data=-128.
- Stub LUT base=0, next=1, in_data frac=8:
  - without ACT_INTERP_ROUND_EN -> 0;
  - with ACT_INTERP_ROUND_EN -> 1.
- Stub LUT base=127, next=-128, frac=1 -> out_data=111; with next=127 under rounding -> no overflow past 127 (saturation check).
- Stream 8 back-to-back samples with out_ready=0 for cycles 3-6:
  - in_ready falls after 2 accepted, out_data and lut_address stay stable;
  - all 8 delivered in order, out_count=8.
- Reset mid-operation: assert rst_n=0 asynchronously mid-burst -> out_valid, out_count and lut_address go to 0 without a clock edge; first sample after release appears 2 cycles after acceptance.

Source files
------------

// File: rtl/act_lut_pkg.sv
// Shared definitions for the activation LUT interpolator.
// Holds default widths, the sample/address/fraction types and the saturation helper
// used by the interpolation datapath.
package act_lut_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned ADDR_W_DEF = 4;
  localparam int unsigned FRAC_W_DEF = DATA_W_DEF - ADDR_W_DEF;
  localparam int unsigned CNT_W_DEF  = 16;

  typedef logic signed [DATA_W_DEF-1:0] sample_t;
  typedef logic        [ADDR_W_DEF-1:0] addr_t;
  typedef logic        [FRAC_W_DEF-1:0] frac_t;

  // Clamp a signed value to the range of a signed word of the given width.
  function automatic logic signed [31:0] sat_data(input logic signed [31:0] val,
                                                  input int unsigned        width);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (width - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (width - 1));
    if (val > hi) begin
      return hi;
    end else if (val < lo) begin
      return lo;
    end
    return val;
  endfunction

endpackage

// File: rtl/act_interp_core.sv
// Combinational interpolation datapath.
// y = sat(lut_base + ((lut_next - lut_base) * frac) >>> FRAC_W)
// Optional macro ACT_INTERP_ROUND_EN: add half an LSB before the shift (round-half-up);
// without it the shift truncates toward -inf.
// Ports:
//   lut_base  in  DATA_W  signed LUT entry at the current address
//   lut_next  in  DATA_W  signed interpolation endpoint
//   frac      in  FRAC_W  unsigned fraction of the sample
//   y         out DATA_W  saturated interpolated value
module act_interp_core
  import act_lut_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned FRAC_W = FRAC_W_DEF
) (
  input  logic signed [DATA_W-1:0] lut_base,
  input  logic signed [DATA_W-1:0] lut_next,
  input  logic        [FRAC_W-1:0] frac,
  output logic signed [DATA_W-1:0] y
);

  localparam int unsigned PW = DATA_W + FRAC_W + 1;

  logic signed [DATA_W:0]   diff;
  logic signed [PW-1:0]     diff_x;
  logic signed [PW-1:0]     frac_x;
  logic signed [PW-1:0]     prod;
  logic signed [PW-1:0]     prod_r;
  logic signed [DATA_W:0]   step;
  logic signed [DATA_W+1:0] sum;

  assign diff   = $signed({lut_next[DATA_W-1], lut_next}) - $signed({lut_base[DATA_W-1], lut_base});
  assign diff_x = $signed({{FRAC_W{diff[DATA_W]}}, diff});
  assign frac_x = $signed({{(PW-FRAC_W){1'b0}}, frac});
  // |diff| <= 2^DATA_W - 1 and frac <= 2^FRAC_W - 1, so PW bits never overflow.
  assign prod   = diff_x * frac_x;

`ifdef ACT_INTERP_ROUND_EN
  assign prod_r = prod + $signed({{(PW-FRAC_W){1'b0}}, 1'b1, {(FRAC_W-1){1'b0}}});
`else
  assign prod_r = prod;
`endif

  // Taking the upper bits is the arithmetic shift right by FRAC_W.
  assign step = prod_r[PW-1:FRAC_W];
  assign sum  = $signed({{2{lut_base[DATA_W-1]}}, lut_base}) + $signed({step[DATA_W], step});
  assign y    = DATA_W'(sat_data(sum, DATA_W));

endmodule

// File: rtl/act_lut_interp.sv
// Activation-function LUT initiator with linear interpolation.
// Two register stages: stage 1 holds the sample and drives the LUT address; the output
// register captures the interpolated value. Full throughput with backpressure.
// Build option: ACT_INTERP_ROUND_EN selects round-half-up instead of truncation.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid/in_ready    input sample handshake, in_data signed sample
//   lut_address          LUT address (upper ADDR_W bits of the staged sample)
//   lut_base/lut_next    combinational LUT returns for lut_address
//   out_valid/out_ready  output handshake, out_data signed activation
//   out_count            completed output handshakes, wraps
module act_lut_interp
  import act_lut_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned FRAC_W = DATA_W - ADDR_W,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  output logic        [ADDR_W-1:0] lut_address,
  input  logic signed [DATA_W-1:0] lut_base,
  input  logic signed [DATA_W-1:0] lut_next,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_data,
  output logic        [CNT_W-1:0]  out_count
);

  logic              v1_q;
  logic [DATA_W-1:0] x1_q;
  logic [FRAC_W-1:0] frac;
  logic signed [DATA_W-1:0] y;
  logic              adv2;

  // Output register can take a new value when empty or being drained this cycle.
  assign adv2     = !out_valid || out_ready;
  // Depends only on registers and out_ready, never on in_valid.
  assign in_ready = !v1_q || adv2;

  assign lut_address = x1_q[DATA_W-1 -: ADDR_W];
  assign frac        = x1_q[FRAC_W-1:0];

  act_interp_core #(
    .DATA_W (DATA_W),
    .FRAC_W (FRAC_W)
  ) u_core (
    .lut_base (lut_base),
    .lut_next (lut_next),
    .frac     (frac),
    .y        (y)
  );

  // Stage 1: sample register feeding the LUT address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q <= 1'b0;
      x1_q <= '0;
    end else if (in_ready) begin
      v1_q <= in_valid;
      if (in_valid) begin
        x1_q <= in_data;
      end
    end
  end

  // Output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (adv2) begin
      out_valid <= v1_q;
      if (v1_q) begin
        out_data <= y;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_count <= '0;
    end else if (out_valid && out_ready) begin
      out_count <= out_count + CNT_W'(1);
    end
  end

endmodule
